// File: rtl/stable_matching_verify.sv
// Sequential stability checker for a candidate suitor/receiver matching; stops on the first blocking pair.
// Optional duplicate-partner pre-check enabled by defining STABLE_MATCHING_DUP_CHECK_EN.
package stable_matching_verify_pkg;
    function automatic int log2(input int n);
        int res;
        res = 0;
        for (int v = n - 1; v > 0; v = v >> 1) res = res + 1;
        if (res == 0) res = 1;
        return res;
    endfunction
endpackage

module stable_matching_verify
    import stable_matching_verify_pkg::*;
#(
    parameter int Ks = 12,
    parameter int Kr = Ks,
    parameter int S  = 16,
    parameter int R  = S
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [R*Kr*log2(S)+S*Ks*log2(R)-1:0]   p_input,
    input  logic [R*log2(S)-1:0]                   o,
    input  logic [R-1:0]                           match_vld,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   stable,
    output logic                                   match_err,
    output logic [log2(S)-1:0]                     bp_s,
    output logic [log2(R)-1:0]                     bp_r
);
    localparam int logS = log2(S);
    localparam int logR = log2(R);
    localparam int logK = log2(Ks);
    localparam int RKW  = log2(Kr + 1);
    localparam int SW   = S * Ks * logR;
    localparam int PW   = SW + R * Kr * logS;

    localparam logic [logR:0]   R_LIM  = (logR + 1)'(R);
    localparam logic [RKW-1:0]  KR_LIM = RKW'(Kr);
    localparam logic [logK-1:0] K_LAST = logK'(Ks - 1);
    localparam logic [logS-1:0] S_LAST = logS'(S - 1);

`ifdef STABLE_MATCHING_DUP_CHECK_EN
    localparam logic [logR-1:0] R_LAST = logR'(R - 1);
    typedef enum logic [1:0] {IDLE, DUP, SCAN, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
`endif

    state_t state_q, state_d;

    logic [PW-1:0]      p_q;
    logic [R*logS-1:0]  o_q;
    logic [R-1:0]       mv_q;
    logic [logS-1:0]    s_q;
    logic [logK-1:0]    k_q;

    logic [logR-1:0]    spref   [S][Ks];
    logic [logS-1:0]    rpref   [R][Kr];
    logic [logS-1:0]    partner [R];

    logic [logR-1:0]    cur_r;
    logic [logS-1:0]    cur_p;
    logic               cur_mv;
    logic               empty;
    logic               own;
    logic               blocking;
    logic               last_k;
    logic               last_s;
    logic [RKW-1:0]     rank_s;
    logic [RKW-1:0]     rank_p;

    // Unpack the captured buses into preference tables and partner list
    always_comb begin
        for (int si = 0; si < S; si++)
            for (int ki = 0; ki < Ks; ki++)
                spref[si][ki] = p_q[(si*Ks + ki)*logR +: logR];
        for (int ri = 0; ri < R; ri++)
            for (int ji = 0; ji < Kr; ji++)
                rpref[ri][ji] = p_q[SW + (ri*Kr + ji)*logS +: logS];
        for (int ri = 0; ri < R; ri++)
            partner[ri] = o_q[ri*logS +: logS];
    end

    // Evaluate the current (s,k) pair; the descending loop leaves the first occurrence as the rank
    always_comb begin
        cur_r  = spref[s_q][k_q];
        empty  = ({1'b0, cur_r} >= R_LIM);
        cur_mv = 1'b0;
        cur_p  = '0;
        if (!empty) begin
            cur_mv = mv_q[cur_r];
            cur_p  = partner[cur_r];
        end
        rank_s = KR_LIM;
        rank_p = KR_LIM;
        for (int j = Kr - 1; j >= 0; j--) begin
            if (!empty && rpref[cur_r][j] == s_q)   rank_s = RKW'(j);
            if (!empty && rpref[cur_r][j] == cur_p) rank_p = RKW'(j);
        end
        own      = cur_mv && (cur_p == s_q);
        blocking = !empty && !own && (rank_s < KR_LIM) && (!cur_mv || (rank_s < rank_p));
        last_k   = (k_q == K_LAST);
        last_s   = (s_q == S_LAST);
    end

`ifdef STABLE_MATCHING_DUP_CHECK_EN
    logic [logR-1:0] d_q;
    logic            dup_hit;

    always_comb begin
        dup_hit = 1'b0;
        for (int e = 0; e < R; e++)
            if (logR'(e) != d_q && mv_q[e] && partner[e] == partner[d_q])
                dup_hit = 1'b1;
        if (!mv_q[d_q]) dup_hit = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef STABLE_MATCHING_DUP_CHECK_EN
                    state_d = DUP;
`else
                    state_d = SCAN;
`endif
                end
            end
`ifdef STABLE_MATCHING_DUP_CHECK_EN
            DUP: begin
                if (dup_hit)               state_d = DONE;
                else if (d_q == R_LAST)    state_d = SCAN;
            end
`endif
            SCAN: begin
                if (blocking || ((own || last_k) && last_s)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Inputs are sampled only when a check is accepted
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            p_q  <= p_input;
            o_q  <= o;
            mv_q <= match_vld;
        end
    end

`ifdef STABLE_MATCHING_DUP_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q       <= '0;
            match_err <= 1'b0;
        end else if (state_q == IDLE && start) begin
            d_q       <= '0;
            match_err <= 1'b0;
        end else if (state_q == DUP && !dup_hit) begin
            d_q       <= d_q + 1'b1;
        end else if (state_q == DUP && dup_hit) begin
            match_err <= 1'b1;
        end
    end
`else
    assign match_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            k_q    <= '0;
            stable <= 1'b0;
            bp_s   <= '0;
            bp_r   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        s_q    <= '0;
                        k_q    <= '0;
                        stable <= 1'b0;
                        bp_s   <= '0;
                        bp_r   <= '0;
                    end
                end
                SCAN: begin
                    if (blocking) begin
                        bp_s   <= s_q;
                        bp_r   <= cur_r;
                        stable <= 1'b0;
                    end else if (own || last_k) begin
                        k_q <= '0;
                        if (last_s) stable <= 1'b1;
                        else        s_q    <= s_q + 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_stable_matching_verify.sv
// Scoreboard bench for stable_matching_verify (S=R=Ks=Kr=4): reference model of the
// stability rules pushes expectations, a negedge monitor pops and compares on done.
module tb_stable_matching_verify;
    localparam int S  = 4;
    localparam int R  = 4;
    localparam int Ks = 4;
    localparam int Kr = 4;
    localparam int LS = 2;
    localparam int LR = 2;
`ifdef STABLE_MATCHING_DUP_CHECK_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] p_input;
    logic [7:0]  o;
    logic [3:0]  match_vld;
    logic        busy, done, stable, match_err;
    logic [1:0]  bp_s, bp_r;

    stable_matching_verify #(.Ks(Ks), .Kr(Kr), .S(S), .R(R)) dut (
        .clk(clk), .rst(rst), .start(start), .p_input(p_input), .o(o),
        .match_vld(match_vld), .busy(busy), .done(done), .stable(stable),
        .match_err(match_err), .bp_s(bp_s), .bp_r(bp_r)
    );

    always #5 clk = ~clk;

    typedef struct { int st; int me; int bs; int br; int n; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int   sp[4][4];
    int   rp[4][4];
    int   part[4];
    logic [3:0] mv;

    int   n_vec = 0;
    int   n_err = 0;
    int   lat = 0;
    bit   busy_prev = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int rank_of(input int r, input int x);
        for (int j = 0; j < Kr; j++) if (rp[r][j] == x) return j;
        return Kr;
    endfunction

    // Reference: duplicate scan (optional) then suitor-major walk of preference slots
    function automatic exp_t model();
        exp_t e;
        int   r, rs;
        e = '{0, 0, 0, 0, 0};
        if (DUP_EN) begin
            for (int d = 0; d < R; d++) begin
                e.n++;
                if (mv[d]) begin
                    for (int f = 0; f < R; f++)
                        if (f != d && mv[f] && part[f] == part[d]) e.me = 1;
                end
                if (e.me == 1) return e;
            end
        end
        for (int s = 0; s < S; s++) begin
            for (int k = 0; k < Ks; k++) begin
                e.n++;
                r = sp[s][k];
                if (mv[r] && part[r] == s) break;
                rs = rank_of(r, s);
                if (rs < Kr && (!mv[r] || rs < rank_of(r, part[r]))) begin
                    e.bs = s;
                    e.br = r;
                    return e;
                end
            end
        end
        e.st = 1;
        return e;
    endfunction

    function automatic logic [63:0] pack_p();
        logic [63:0] v;
        v = '0;
        for (int s = 0; s < S; s++)
            for (int k = 0; k < Ks; k++) v[(s*Ks + k)*LR +: LR] = LR'(sp[s][k]);
        for (int r = 0; r < R; r++)
            for (int j = 0; j < Kr; j++) v[32 + (r*Kr + j)*LS +: LS] = LS'(rp[r][j]);
        return v;
    endfunction

    function automatic logic [7:0] pack_o();
        logic [7:0] v;
        for (int r = 0; r < R; r++) v[r*LS +: LS] = LS'(part[r]);
        return v;
    endfunction

    task automatic set_identity();
        for (int a = 0; a < 4; a++) begin
            part[a] = a;
            for (int b = 0; b < 4; b++) begin
                sp[a][b] = b;
                rp[a][b] = b;
            end
        end
        mv = 4'hF;
    endtask

    task automatic issue_start();
        @(negedge clk);
        p_input   = pack_p();
        o         = pack_o();
        match_vld = mv;
        start     = 1'b1;
        exp_q.push_back(model());
        @(negedge clk);
        start     = 1'b0;
        p_input   = {$urandom, $urandom};
        o         = 8'($urandom);
        match_vld = 4'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_stable"}, stable, 0);
        check({tag, "_match_err"}, match_err, 0);
        check({tag, "_bp_s"}, bp_s, 0);
        check({tag, "_bp_r"}, bp_r, 0);
    endtask

    task automatic shuffle_row(input bit is_s, input int row);
        int j, tmp;
        for (int i = 3; i > 0; i--) begin
            j = $urandom_range(i, 0);
            if (is_s) begin tmp = sp[row][i]; sp[row][i] = sp[row][j]; sp[row][j] = tmp; end
            else      begin tmp = rp[row][i]; rp[row][i] = rp[row][j]; rp[row][j] = tmp; end
        end
    endtask

    // Monitor: tracks cycles since busy rose and scores each done pulse
    always @(negedge clk) begin
        if (rst) begin
            busy_prev = 1'b0;
        end else begin
            if (busy && !busy_prev) lat = 0;
            else if (busy)          lat++;
            busy_prev = busy;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("stable", stable, mon_e.st);
                    check("match_err", match_err, mon_e.me);
                    check("bp_s", bp_s, mon_e.bs);
                    check("bp_r", bp_r, mon_e.br);
                    check("latency", lat, mon_e.n);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; p_input = '0; o = '0; match_vld = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Identity, swapped pair, unmatched receiver, duplicate partner
        set_identity();
        issue_start(); wait_idle();
        set_identity(); part[0] = 1; part[1] = 0;
        issue_start(); wait_idle();
        set_identity(); mv = 4'h7;
        issue_start(); wait_idle();
        set_identity(); part[1] = 0;
        issue_start(); wait_idle();

        // Reset while idle clears the held stable result, then reset mid-scan
        set_identity();
        issue_start(); wait_idle();
        #2 rst = 1'b1;
        #1 check("idle_reset_stable", stable, 0);
        @(negedge clk); rst = 1'b0;
        issue_start();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midreset");
        exp_q.delete();
        @(negedge clk); rst = 1'b0;
        issue_start(); wait_idle();

        // Start pulsed at E3 while busy is ignored
        set_identity();
        issue_start();
        @(negedge clk);
        set_identity(); part[0] = 1; part[1] = 0;
        p_input = pack_p(); o = pack_o(); match_vld = mv; start = 1'b1;
        @(negedge clk); start = 1'b0;
        set_identity();
        wait_idle();

        // Start coincident with done is ignored
        issue_start();
        t = 0;
        while (!done && t < 100) begin @(negedge clk); t++; end
        check("done_seen", done, 1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (30) @(negedge clk);
        check("no_extra_busy", busy, 0);

        // Randomized matchings and preference lists
        for (int it = 0; it < 40; it++) begin
            set_identity();
            for (int a = 0; a < 4; a++) begin
                shuffle_row(1'b1, a);
                shuffle_row(1'b0, a);
                if ($urandom_range(3, 0) == 0)
                    for (int b = 0; b < 4; b++) sp[a][b] = $urandom_range(3, 0);
            end
            if ($urandom_range(1, 0) == 1) begin
                for (int i = 3; i > 0; i--) begin
                    int j, tmp;
                    j = $urandom_range(i, 0);
                    tmp = part[i]; part[i] = part[j]; part[j] = tmp;
                end
            end else begin
                for (int a = 0; a < 4; a++) part[a] = $urandom_range(3, 0);
            end
            mv = ($urandom_range(1, 0) == 1) ? 4'hF : 4'($urandom);
            issue_start(); wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
